// File: rtl/clause_bound_accumulator_pkg.sv
// Shared constants for the clause bound accumulator: default widths, bound type and FSM encodings.
package clause_bound_accumulator_pkg;

  localparam int DEF_W       = 8;
  localparam int DEF_CLAUSES = 4;

  // One guard bit so that negating the most negative bias cannot wrap.
  typedef logic signed [DEF_W:0] bound_t;

  localparam bound_t BOUND_MIN = $signed({2'b11, {(DEF_W-1){1'b0}}});
  localparam bound_t BOUND_MAX = $signed({2'b00, {(DEF_W-1){1'b1}}});

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/clause_bound_accumulator_bound_update.sv
// Combinational next-bound logic: +y<=b tightens hi, -y<=b tightens lo; inactive clauses pass through.
module bound_update #(
  parameter int W = 8
) (
  input  logic signed [W:0]   lo_i,
  input  logic signed [W:0]   hi_i,
  input  logic        [W-1:0] b_i,
  input  logic                sign_i,
  input  logic                active_i,
  output logic signed [W:0]   lo_o,
  output logic signed [W:0]   hi_o
);

  logic signed [W:0] b_ext;
  logic signed [W:0] neg_b;

  assign b_ext = {b_i[W-1], b_i};
  assign neg_b = -b_ext;

  always_comb begin
    lo_o = lo_i;
    hi_o = hi_i;
    if (active_i) begin
      if (sign_i) begin
        if (neg_b > lo_i) lo_o = neg_b;
      end else begin
        if (b_ext < hi_i) hi_o = b_ext;
      end
    end
  end

endmodule

// File: rtl/clause_bound_accumulator.sv
// Intersects a stream of reduced clauses into one [lower, upper] interval; outputs update one cycle after each beat.
// Ready only while accumulating and not restarting. BOUND_ACC_EMPTY_CHECK_EN builds the registered empty flag.
module clause_bound_accumulator
  import clause_bound_accumulator_pkg::*;
#(
  parameter int BIT_WIDTH_OF_INTEGER_VARIABLE = DEF_W,
  parameter int NUMBER_OF_CLAUSES             = DEF_CLAUSES
) (
  input  logic                                     in_clk,
  input  logic                                     in_reset_n,
  input  logic                                     in_start,
  input  logic                                     in_clause_valid,
  output logic                                     out_clause_ready,
  input  logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_bias,
  input  logic                                     in_sign,
  input  logic                                     in_active,
  output logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_lower,
  output logic [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_upper,
  output logic                                     out_done,
  output logic                                     out_empty
);

  localparam int W  = BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int CW = (NUMBER_OF_CLAUSES > 1) ? $clog2(NUMBER_OF_CLAUSES) : 1;
  localparam logic signed [W:0] LO_INIT = $signed({2'b11, {(W-1){1'b0}}});
  localparam logic signed [W:0] HI_INIT = $signed({2'b00, {(W-1){1'b1}}});
  localparam logic [CW-1:0]     LAST    = CW'(NUMBER_OF_CLAUSES - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic signed [W:0] lo_q, lo_d, hi_q, hi_d;
  logic signed [W:0] lo_upd, hi_upd;
  logic              accept;

  assign out_clause_ready = (state_q == ST_ACCUM) && !in_start;
  assign accept           = in_clause_valid && out_clause_ready;

  bound_update #(.W(W)) u_bound_update (
    .lo_i     (lo_q),
    .hi_i     (hi_q),
    .b_i      (in_bias),
    .sign_i   (in_sign),
    .active_i (in_active),
    .lo_o     (lo_upd),
    .hi_o     (hi_upd)
  );

  // The counter stops at terminal count; leaving ACCUM is what prevents a wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (in_start) begin
      state_d = ST_ACCUM;
      cnt_d   = '0;
      lo_d    = LO_INIT;
      hi_d    = HI_INIT;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            lo_d = lo_upd;
            hi_d = hi_upd;
            if (cnt_q == LAST) state_d = ST_DONE;
            else               cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  function automatic logic [W-1:0] saturate(input logic signed [W:0] v);
    if (v > HI_INIT)      return HI_INIT[W-1:0];
    else if (v < LO_INIT) return LO_INIT[W-1:0];
    else                  return v[W-1:0];
  endfunction

  assign out_lower = saturate(lo_q);
  assign out_upper = saturate(hi_q);
  assign out_done  = (state_q == ST_DONE);

`ifdef BOUND_ACC_EMPTY_CHECK_EN
  logic empty_q, empty_d;

  // Compared on the guarded values, so a clamped lower of MAX still reads as empty.
  assign empty_d = in_start ? 1'b0 : (lo_d > hi_d);

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) empty_q <= 1'b0;
    else             empty_q <= empty_d;
  end

  assign out_empty = empty_q;
`else
  assign out_empty = 1'b0;
`endif

endmodule

// File: tb/tb_clause_bound_accumulator.sv
// Self-checking bench for clause_bound_accumulator at W=8, N=4: table of clause sets plus reset/restart corner cases.
module tb_clause_bound_accumulator;

`ifdef BOUND_ACC_EMPTY_CHECK_EN
  localparam bit EMP_EN = 1'b1;
`else
  localparam bit EMP_EN = 1'b0;
`endif

  typedef struct packed {
    logic signed [7:0] b;
    logic              s;
    logic              a;
  } beat_t;

  typedef struct packed {
    beat_t [3:0]       bt;
    logic signed [7:0] lo;
    logic signed [7:0] hi;
    logic              emp;
  } vec_t;

  typedef struct packed {
    logic signed [7:0] lo;
    logic signed [7:0] hi;
    logic              emp;
  } exp_t;

  logic       in_clk = 1'b0;
  logic       in_reset_n;
  logic       in_start;
  logic       in_clause_valid;
  logic       out_clause_ready;
  logic [7:0] in_bias;
  logic       in_sign;
  logic       in_active;
  logic [7:0] out_lower;
  logic [7:0] out_upper;
  logic       out_done;
  logic       out_empty;

  int   checks = 0;
  int   passes = 0;
  exp_t sbq[$];
  vec_t vecs[5];

  clause_bound_accumulator #(
    .BIT_WIDTH_OF_INTEGER_VARIABLE (8),
    .NUMBER_OF_CLAUSES             (4)
  ) dut (
    .in_clk           (in_clk),
    .in_reset_n       (in_reset_n),
    .in_start         (in_start),
    .in_clause_valid  (in_clause_valid),
    .out_clause_ready (out_clause_ready),
    .in_bias          (in_bias),
    .in_sign          (in_sign),
    .in_active        (in_active),
    .out_lower        (out_lower),
    .out_upper        (out_upper),
    .out_done         (out_done),
    .out_empty        (out_empty)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  function automatic beat_t bb(input int b, input bit s, input bit a);
    beat_t r;
    r.b = 8'(b);
    r.s = s;
    r.a = a;
    return r;
  endfunction

  function automatic vec_t mkv(input beat_t b0, input beat_t b1, input beat_t b2, input beat_t b3,
                               input int lo, input int hi, input bit emp);
    vec_t v;
    v.bt[0] = b0; v.bt[1] = b1; v.bt[2] = b2; v.bt[3] = b3;
    v.lo = 8'(lo);
    v.hi = 8'(hi);
    v.emp = emp;
    return v;
  endfunction

  task automatic drive_beat(input beat_t bt, input string nm);
    in_clause_valid = 1'b1;
    in_bias         = bt.b;
    in_sign         = bt.s;
    in_active       = bt.a;
    #1;
    chk({nm, "_ready"}, int'(out_clause_ready), 1);
    step();
    in_clause_valid = 1'b0;
  endtask

  task automatic start_interval(input string nm);
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    chk({nm, "_start_lower"}, int'($signed(out_lower)), -128);
    chk({nm, "_start_upper"}, int'($signed(out_upper)), 127);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    exp_t got;
    int   lat;
    start_interval(nm);
    e.lo = v.lo;
    e.hi = v.hi;
    e.emp = v.emp & EMP_EN;
    sbq.push_back(e);
    for (int i = 0; i < 4; i++) begin
      drive_beat(v.bt[i], nm);
      if (i < 3) chk({nm, "_early_done"}, int'(out_done), 0);
    end
    lat = 0;
    while (!out_done && lat < 8) begin
      step();
      lat++;
    end
    chk({nm, "_done_latency"}, lat, 0);
    got = sbq.pop_front();
    chk({nm, "_lower"}, int'($signed(out_lower)), int'(got.lo));
    chk({nm, "_upper"}, int'($signed(out_upper)), int'(got.hi));
    chk({nm, "_empty"}, int'(out_empty), int'(got.emp));
    step();
    chk({nm, "_done_pulse"}, int'(out_done), 0);
    chk({nm, "_hold_upper"}, int'($signed(out_upper)), int'(got.hi));
  endtask

  initial begin
    vecs[0] = mkv(bb(1, 0, 1), bb(0, 1, 1), bb(5, 0, 1), bb(9, 0, 0), 0, 1, 1'b0);
    vecs[1] = mkv(bb(3, 0, 0), bb(-7, 1, 0), bb(0, 0, 0), bb(100, 1, 0), -128, 127, 1'b0);
    vecs[2] = mkv(bb(-128, 1, 1), bb(0, 0, 0), bb(0, 1, 0), bb(0, 0, 0), 127, 127, 1'b1);
    vecs[3] = mkv(bb(2, 0, 1), bb(-5, 1, 1), bb(0, 0, 0), bb(0, 0, 0), 5, 2, 1'b1);
    vecs[4] = mkv(bb(-128, 0, 1), bb(127, 1, 1), bb(-3, 1, 1), bb(50, 0, 0), 3, -128, 1'b1);

    in_reset_n      = 1'b0;
    in_start        = 1'b0;
    in_clause_valid = 1'b1;
    in_bias         = 8'd0;
    in_sign         = 1'b0;
    in_active       = 1'b0;
    #12;
    chk("reset_lower", int'(out_lower), 0);
    chk("reset_upper", int'(out_upper), 0);
    chk("reset_done",  int'(out_done), 0);
    chk("reset_empty", int'(out_empty), 0);
    chk("reset_ready", int'(out_clause_ready), 0);
    @(negedge in_clk);
    in_reset_n = 1'b1;
    step();
    chk("idle_ignores_valid", int'(out_clause_ready), 0);
    in_clause_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an interval.
    start_interval("midrst");
    drive_beat(bb(10, 0, 1), "midrst");
    drive_beat(bb(-4, 1, 1), "midrst");
    in_clause_valid = 1'b1;
    #2;
    in_reset_n = 1'b0;
    #1;
    chk("midrst_lower", int'(out_lower), 0);
    chk("midrst_upper", int'(out_upper), 0);
    chk("midrst_done",  int'(out_done), 0);
    chk("midrst_empty", int'(out_empty), 0);
    chk("midrst_ready", int'(out_clause_ready), 0);
    step();
    in_clause_valid = 1'b0;
    @(negedge in_clk);
    in_reset_n = 1'b1;
    step();
    run_vec(vecs[0], "after_rst");

    // Restart while a beat is presented: the beat is dropped and the count starts over.
    start_interval("restart");
    drive_beat(bb(3, 0, 1), "restart");
    in_start        = 1'b1;
    in_clause_valid = 1'b1;
    in_bias         = 8'(-50);
    in_sign         = 1'b0;
    in_active       = 1'b1;
    #1;
    chk("restart_ready_low", int'(out_clause_ready), 0);
    step();
    in_start        = 1'b0;
    in_clause_valid = 1'b0;
    chk("restart_upper_cleared", int'($signed(out_upper)), 127);
    drive_beat(bb(4, 0, 1), "restart");
    drive_beat(bb(0, 0, 0), "restart");
    drive_beat(bb(0, 1, 0), "restart");
    chk("restart_no_done_at_3", int'(out_done), 0);
    drive_beat(bb(0, 0, 0), "restart");
    chk("restart_done_at_4", int'(out_done), 1);
    chk("restart_upper", int'($signed(out_upper)), 4);
    chk("restart_lower", int'($signed(out_lower)), -128);
    step();
    chk("restart_done_pulse", int'(out_done), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
